// File: rtl/tt_um_exp_prng_lfsr_pkg.sv
// Shared constants and types for the exponential/Bernoulli PRNG.
//   LFSR_W      : width of the generator state
//   TAP_*       : feedback taps of x^32+x^22+x^2+x+1 (bit positions 31,21,1,0)
//   RESET_SEED  : state after reset; also replaces an all-zero loaded seed
//   mode_e      : uo_out source select
//   ctrl_t      : field view of ui_in {thr, mode, load, run}
package tt_um_exp_prng_lfsr_pkg;

   localparam int LFSR_W = 32;
   localparam int SEED_W = 8;

   localparam int TAP_A = 31;
   localparam int TAP_B = 21;
   localparam int TAP_C = 1;
   localparam int TAP_D = 0;

   localparam logic [LFSR_W-1:0] RESET_SEED = 32'h0000_0001;

   typedef enum logic [1:0] {
      MODE_RAW_LO = 2'b00,
      MODE_RAW_HI = 2'b01,
      MODE_EXP    = 2'b10,
      MODE_BERN   = 2'b11
   } mode_e;

   // Packed MSB-first, so a cast of ui_in lands each field on its pins.
   typedef struct packed {
      logic [3:0] thr;
      mode_e      mode;
      logic       load;
      logic       run;
   } ctrl_t;

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
   endfunction

endpackage

// File: rtl/tt_um_exp_prng_lfsr_lfsr32.sv
// lfsr32: 32-bit Fibonacci LFSR state with byte-wise seed loading.
//   clk, rst_n : clock, async active-low reset (state -> RESET_SEED)
//   ena        : when low the state holds regardless of load/run
//   load       : shift seed_byte into the low byte (has priority over run)
//   run        : advance the LFSR by one step
//   seed_byte  : seed data, used only when load=1
//   state      : current generator state, never all-zero
module lfsr32
   import tt_um_exp_prng_lfsr_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              load,
   input  logic              run,
   input  logic [SEED_W-1:0] seed_byte,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] shifted;
   logic [LFSR_W-1:0] next;

   always_comb begin
      shifted = {state[LFSR_W-SEED_W-1:0], seed_byte};
      next    = state;
      if (load) begin
         // All-zero is the LFSR's lock-up state; substitute the reset seed.
         next = (shifted == '0) ? RESET_SEED : shifted;
      end else if (run) begin
         next = {state[LFSR_W-2:0], lfsr_fb(state)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= RESET_SEED;
      else if (ena) state <= next;
   end

endmodule

// File: rtl/tt_um_exp_prng_lfsr.sv
// tt_um_exp_prng_lfsr: LFSR-based PRNG with raw, exponential and Bernoulli outputs.
//   clk, rst_n : clock, async active-low reset
//   ena        : design enable (state holds when low)
//   ui_in      : [0] run, [1] load, [3:2] mode, [7:4] thr
//   uio_in     : seed byte, sampled when load=1
//   uo_out     : mode 00 S[7:0], 01 S[31:24], 10 clz(S), 11 (S[31:28] < thr)
//   uio_out    : constant 0
//   uio_oe     : constant 0, all uio pins are inputs
// Output selection is purely combinational, so mode/thr changes show on
// uo_out at once and never disturb the state.
module tt_um_exp_prng_lfsr
   import tt_um_exp_prng_lfsr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   ctrl_t             ctrl;
   logic [LFSR_W-1:0] s;
   logic [4:0]        clz;
   logic              bern;

   assign ctrl = ctrl_t'(ui_in);

   lfsr32 u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .load      (ctrl.load),
      .run       (ctrl.run),
      .seed_byte (uio_in),
      .state     (s)
   );

   // Leading-zero count: scanning upward, the last set bit seen is the
   // most significant one. S is never zero, so the result fits 0..31.
   always_comb begin
      clz = 5'd31;
      for (int i = 0; i < LFSR_W; i++) begin
         if (s[i]) clz = 5'(LFSR_W - 1 - i);
      end
   end

   // Top nibble is uniform over 1..15 (and 0), giving P(1) ~ thr/16.
   assign bern = (s[LFSR_W-1 -: 4] < ctrl.thr);

   always_comb begin
      uo_out = '0;
      case (ctrl.mode)
         MODE_RAW_LO: uo_out = s[7:0];
         MODE_RAW_HI: uo_out = s[LFSR_W-1 -: 8];
         MODE_EXP:    uo_out = {3'b000, clz};
         MODE_BERN:   uo_out = {7'b0000000, bern};
         default:     uo_out = '0;
      endcase
   end

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_exp_prng_lfsr.sv
module tb_tt_um_exp_prng_lfsr;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] s_m;   // reference model state

   tt_um_exp_prng_lfsr dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] ui;
      logic [7:0] exp;
   } vec_t;

   // Reference: the spec's rules written arithmetically.
   function automatic logic [31:0] ref_next(logic [31:0] s, logic en,
                                            logic [7:0] ui, logic [7:0] seed);
      logic [31:0] n;
      n = s;
      if (en) begin
         if (ui[1]) begin
            n = (s << 8) | 32'(seed);
            if (n == 0) n = 32'd1;
         end else if (ui[0]) begin
            // taps 31,21,1,0 -> parity of masked state
            n = (s << 1) | 32'(^(s & 32'h8020_0003));
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] ref_out(logic [31:0] s, logic [1:0] mode, logic [3:0] thr);
      int lz;
      lz = 0;
      while (lz < 32 && !s[31-lz]) lz++;
      case (mode)
         2'd0:    return s[7:0];
         2'd1:    return s[31:24];
         2'd2:    return 8'(lz);
         default: return ((s >> 28) < 32'(thr)) ? 8'd1 : 8'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge.
   task automatic cyc();
      logic [31:0] nxt;
      nxt = rst_n ? ref_next(s_m, ena, ui_in, uio_in) : 32'd1;
      @(posedge clk);
      #1;
      s_m = nxt;
   endtask

   function automatic logic [7:0] ctl(logic run, logic load, logic [1:0] mode, logic [3:0] thr);
      return {thr, mode, load, run};
   endfunction

   task automatic load_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) begin
         ui_in  = ctl(1'b0, 1'b1, 2'd0, 4'd0);
         uio_in = w[i*8 +: 8];
         cyc();
      end
      ui_in = ctl(1'b0, 1'b0, 2'd0, 4'd0);
   endtask

   vec_t rst_tab[7];
   logic [7:0] step_exp[3];
   logic [7:0] hold_val;

   initial begin
      rst_tab[0] = '{1'b1, ctl(1'b1, 1'b0, 2'd0, 4'h0), 8'h01};
      rst_tab[1] = '{1'b1, ctl(1'b1, 1'b1, 2'd1, 4'h0), 8'h00};
      rst_tab[2] = '{1'b0, ctl(1'b0, 1'b1, 2'd2, 4'h0), 8'h1F};
      rst_tab[3] = '{1'b1, ctl(1'b0, 1'b0, 2'd3, 4'h0), 8'h00};
      rst_tab[4] = '{1'b1, ctl(1'b1, 1'b0, 2'd3, 4'h1), 8'h01};
      rst_tab[5] = '{1'b0, ctl(1'b0, 1'b0, 2'd3, 4'hF), 8'h01};
      rst_tab[6] = '{1'b1, ctl(1'b1, 1'b1, 2'd0, 4'h7), 8'h01};
      step_exp[0] = 8'h03; step_exp[1] = 8'h06; step_exp[2] = 8'h0D;

      // Reset state across modes, with clocks, run/load and ena toggling.
      #3 rst_n = 1'b0;
      s_m = 32'd1;
      for (int i = 0; i < 7; i++) begin
         ena   = rst_tab[i].en;
         ui_in = rst_tab[i].ui;
         uio_in = 8'hA5;
         cyc();
         cyc();
         check($sformatf("reset_out[%0d]", i), uo_out, rst_tab[i].exp);
      end
      check("reset_uio_out", uio_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);

      // Release reset and step three times in mode 00.
      ena   = 1'b1;
      ui_in = ctl(1'b1, 1'b0, 2'd0, 4'd0);
      rst_n = 1'b1;
      #1 check("step_0", uo_out, 8'h01);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("step_%0d", i + 1), uo_out, step_exp[i]);
         check($sformatf("step_model_%0d", i + 1), uo_out, ref_out(s_m, 2'd0, 4'd0));
      end

      // Seed load DEADBEEF.
      load_word(32'hDEAD_BEEF);
      ui_in = ctl(1'b0, 1'b0, 2'd1, 4'd0); #1 check("seed_hi", uo_out, 8'hDE);
      ui_in = ctl(1'b0, 1'b0, 2'd0, 4'd0); #1 check("seed_lo", uo_out, 8'hEF);
      ui_in = ctl(1'b0, 1'b0, 2'd2, 4'd0); #1 check("seed_exp", uo_out, 8'h00);

      // Bernoulli around the top nibble D.
      ui_in = ctl(1'b0, 1'b0, 2'd3, 4'hF); #1 check("bern_thrF", uo_out, 8'h01);
      ui_in = ctl(1'b0, 1'b0, 2'd3, 4'hD); #1 check("bern_thrD", uo_out, 8'h00);
      ui_in = ctl(1'b0, 1'b0, 2'd3, 4'hE); #1 check("bern_thrE", uo_out, 8'h01);
      ui_in = ctl(1'b0, 1'b0, 2'd3, 4'h0); #1 check("bern_thr0", uo_out, 8'h00);

      // Enable gating: nothing moves for 10 clocks.
      ena    = 1'b0;
      uio_in = 8'h55;
      ui_in  = ctl(1'b1, 1'b1, 2'd0, 4'd0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check($sformatf("ena_hold_%0d", i), uo_out, 8'hEF);
      end
      ui_in = ctl(1'b1, 1'b1, 2'd1, 4'd0); #1 check("ena_hold_hi", uo_out, 8'hDE);
      ena = 1'b1;

      // Zero-seed protection.
      load_word(32'h0000_0000);
      ui_in = ctl(1'b0, 1'b0, 2'd2, 4'd0); #1 check("zero_exp", uo_out, 8'h1F);
      ui_in = ctl(1'b0, 1'b0, 2'd0, 4'd0); #1 check("zero_lo", uo_out, 8'h01);
      ui_in = ctl(1'b0, 1'b0, 2'd1, 4'd0); #1 check("zero_hi", uo_out, 8'h00);

      // Reset in the middle of a load, away from any clock edge.
      load_word(32'h1234_5678);
      ui_in = ctl(1'b0, 1'b1, 2'd0, 4'd0);
      uio_in = 8'hAB; cyc();
      uio_in = 8'hCD; cyc();
      #2 rst_n = 1'b0;
      s_m = 32'd1;
      #1 check("midload_rst_async", uo_out, 8'h01);
      cyc();
      rst_n = 1'b1;
      uio_in = 8'h11; cyc();
      uio_in = 8'h22; cyc();
      ui_in = ctl(1'b0, 1'b0, 2'd0, 4'd0); #1 check("midload_lo", uo_out, 8'h22);
      ui_in = ctl(1'b0, 1'b0, 2'd1, 4'd0); #1 check("midload_hi", uo_out, 8'h00);

      // Randomized traffic against the model, all four modes per cycle.
      for (int it = 0; it < 400; it++) begin
         ena    = ($urandom_range(0, 9) != 0);
         ui_in  = 8'($urandom);
         uio_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         cyc();
         for (int m = 0; m < 4; m++) begin
            ui_in[3:2] = 2'(m);
            ui_in[7:4] = 4'($urandom);
            #1 check($sformatf("rand_%0d_m%0d", it, m), uo_out,
                     ref_out(s_m, ui_in[3:2], ui_in[7:4]));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_exp_prng_lfsr.md
TT_UM_EXP_PRNG_LFSR -- requirements
Module: tt_um_exp_prng_lfsr

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-003 SHALL have the port ena, input, 1 bit: design enable; when low, all state holds.
REQ-004 SHALL have the port ui_in, input, 8 bits, decoded as follows:
- [0] run: step the LFSR.
- [1] load: shift in a seed byte.
- [3:2] mode: output select.
- [7:4] thr: threshold.
REQ-005 SHALL have the port uio_in, input, 8 bits: seed byte, sampled only when load=1.
REQ-006 SHALL have the port uo_out, output, 8 bits: generator output.
REQ-007 SHALL have the port uio_out, output, 8 bits: tied to 8'h00.
REQ-008 SHALL have the port uio_oe, output, 8 bits: tied to 8'h00 (all uio pins are inputs).

Function
REQ-009 SHALL hold a 32-bit state register S, Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1:
- fb = S[31]^S[21]^S[1]^S[0]
- step: S <= {S[30:0], fb}.
REQ-010 SHALL, per rising clk edge, apply the first matching rule in this priority order:
- ena=0: hold.
- load=1: S <= {S[23:0], uio_in}.
- run=1: step.
- otherwise: hold.
REQ-011 SHALL, when a load would produce S == 0, store 32'h0000_0001 instead; S is never all-zero.
REQ-012 SHALL drive uo_out combinationally from current S and mode; a new S is visible on uo_out in the cycle after the clock edge that wrote it:
- mode 00: S[7:0].
- mode 01: S[31:24].
- mode 10 (exponential): {3'b0, clz(S)}, where clz = number of leading zeros of S, range 0..31.
- mode 11 (Bernoulli): {7'b0, (S[31:28] < thr)}, unsigned compare.
REQ-013 SHALL let mode and thr change uo_out immediately without affecting S.
REQ-014 SHALL produce a non-repeating sequence of period 2^32-1 under continuous run.

Reset
REQ-015 SHALL set S to 32'h0000_0001 asynchronously while rst_n=0, regardless of clk and ena.
REQ-016 SHALL produce the following reset-state outputs:
- mode 00: uo_out=8'h01.
- mode 01: uo_out=8'h00.
- mode 10: uo_out=8'h1F.
- mode 11: uo_out=8'h01 iff thr>0.
- uio_out=8'h00 and uio_oe=8'h00 always.
REQ-017 SHALL abandon any partially shifted seed when reset is asserted during a load sequence; the reset seed wins.

Structure
REQ-018 SHALL place the following in a shared package:
- LFSR width (32).
- Tap positions (31,21,1,0).
- Reset seed (32'h1).
- Mode encodings (RAW_LO, RAW_HI, EXP, BERN).
REQ-019 SHALL implement the state register, load and step logic in one sub-module, lfsr32. The top level contains only the mode mux, clz and compare.

Verification
REQ-020 SHALL verify reset and stepping: reset with mode 00 and run=1 for 3 clocks -> uo_out 8'h01, then 8'h03, 8'h06, 8'h0D.
REQ-021 SHALL verify seed load: load=1 with uio_in DE, AD, BE, EF over 4 clocks -> mode 01 gives 8'hDE, mode 00 gives 8'hEF, mode 10 gives 8'h00.
REQ-022 SHALL verify zero-seed protection: load 4 bytes of 8'h00 -> S=1, mode 10 gives 8'h1F, mode 00 gives 8'h01.
REQ-023 SHALL verify Bernoulli mode with S=32'hDEADBEEF and mode 11 -> thr=4'hF gives 8'h01, thr=4'hD gives 8'h00.
REQ-024 SHALL verify enable gating: ena=0 with run=1 and load=1 for 10 clocks -> uo_out unchanged.
REQ-025 SHALL verify reset mid-load: assert rst_n=0 after 2 seed bytes -> mode 00 gives 8'h01 immediately, without waiting for a clock edge.
